aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequencing controller for the AES-128 encryption datapath core. It converts a single-cycle start request into the per-cycle control stream the core consumes: accept, round number, and the SubBytes/ShiftRows/MixColumns/AddRoundKey/KeySchedule stage enables. It sits directly upstream of the core, one encryption in flight at a time, and reports busy/done to the testbench. Core contract: any stage with enable=0 passes its input through unchanged, and the core registers round_key and cipher_text on every clock edge.

Parameters:
NR, 10, number of cipher rounds after the initial AddRoundKey (legal 2..15; 10 for AES-128).

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
start  input  1  request one encryption; sampled in IDLE or DONE only
accept  output  1  core selects plain_text/cipher_key (1) or its registered state/round_key (0)
rndNo  output  4  current round number, 0..NR
enbSB  output  1  SubBytes enable
enbSR  output  1  ShiftRows enable
enbMC  output  1  MixColumns enable
enbAR  output  1  AddRoundKey enable
enbKS  output  1  KeySchedule enable
busy  output  1  high while a round sequence is in flight (RND0..FINAL)
done  output  1  one-cycle pulse; core cipher_text holds the result in this cycle

Behaviour:
- Reset: rstn is sampled only on posedge clk; rstn=0 forces state=IDLE and round counter=0. In IDLE all outputs are 0 (accept=0, rndNo=0, all enables 0, busy=0, done=0).
- Outputs are Moore: decoded only from the registered state and round counter, never from start.
- States:
  - IDLE: start=1 -> RND0; otherwise stay.
  - RND0 (1 cycle): accept=1, rndNo=0, enbAR=1, enbSB=enbSR=enbMC=enbKS=0, busy=1. The core captures plain_text^cipher_key and cipher_key. Next state is RNDS with counter=1.
  - RNDS (NR-1 cycles): accept=0, rndNo=counter, all five enables=1, busy=1. Counter increments each cycle. When counter==NR-1 -> FINAL, counter=NR.
  - FINAL (1 cycle): accept=0, rndNo=NR, enbSB=enbSR=enbAR=enbKS=1, enbMC=0, busy=1. Next state is DONE.
  - DONE (1 cycle): done=1, busy=0, accept=0, rndNo=0, all enables 0. Core registers hold cipher_text (enable=0 pass-through; the core's inSB mux selects cipher_text, so AR with enbAR=0 recirculates it). start=1 -> RND0 (back-to-back); otherwise -> IDLE.
- Latency: start=1 sampled at edge E0 -> RND0 in cycle after E0. The ciphertext is registered at the edge ending FINAL. done is high for the NR+2nd cycle after E0 (cycle 12 for NR=10). Back-to-back throughput is one block per NR+2 cycles.
- start is ignored in RND0, RNDS and FINAL; it is not queued.
- Counter width is 4 bits; it never exceeds NR, so there is no wrap.
- Reset mid-operation (any state): the next edge returns to IDLE and all outputs go to 0. No done pulse is produced for the aborted block.
- Simultaneous rstn=0 and start=1: reset wins.
- At most one of {IDLE, RND0, RNDS, FINAL, DONE} is active. Unreachable encodings recover to IDLE on the next edge.

Test Plan:
- Reset/idle: hold rstn=0 for 3 cycles with start=1, then release with start=0 for 5 cycles -> all outputs 0 throughout, busy=0, no done.
- Sequence check (NR=10): pulse start for 1 cycle -> the rndNo sequence is 0,1,...,10. accept=1 only at rndNo=0. Enables at rndNo=0 are {AR} only; at 1..9 they are all five; at 10 they are all except MC. done is high exactly 12 cycles after the start edge and lasts 1 cycle.
- End-to-end with core, FIPS-197 C.1: plain_text=00112233445566778899aabbccddeeff, cipher_key=000102030405060708090a0b0c0d0e0f -> cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a while done=1, and unchanged in the following IDLE cycles.
- Start ignored while busy: assert start at rndNo=3 and rndNo=10 -> the sequence is unaffected and only one done pulse occurs. Asserting start during DONE launches a second block immediately (accept=1 the next cycle), and both ciphertexts are correct.
- Reset mid-operation: drop rstn for 1 cycle at rndNo=5 -> the next cycle shows IDLE outputs with no done. A subsequent start produces the correct FIPS-197 ciphertext.
- Parameter: NR=4 -> rndNo runs 0..4, MC is off only at 4, and done appears 6 cycles after start.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Purpose:
//   Sequencing controller for an AES-128 encryption datapath core. A one-cycle
//   start request launches one block: RND0 (initial AddRoundKey), NR-1 full
//   rounds, then a FINAL round without MixColumns, followed by a single DONE
//   cycle. In DONE the core's registered state already holds the ciphertext.
//   Outputs are Moore: decoded only from the registered state and round counter.
//   Only one block is in flight at a time. start is ignored while busy and is
//   not queued. A start seen in DONE launches the next block back-to-back.
//
// Parameters:
//   NR     number of cipher rounds after the initial AddRoundKey (2..15)
//
// Ports:
//   clk    in   clock
//   rstn   in   synchronous active-low reset
//   start  in   request one encryption (sampled in IDLE or DONE only)
//   accept out  core loads plain_text/cipher_key (1) or recirculates (0)
//   rndNo  out  current round number 0..NR (0 outside a round sequence)
//   enbSB  out  SubBytes enable
//   enbSR  out  ShiftRows enable
//   enbMC  out  MixColumns enable
//   enbAR  out  AddRoundKey enable
//   enbKS  out  KeySchedule enable
//   busy   out  high during RND0..FINAL
//   done   out  one-cycle pulse, ciphertext valid at the core this cycle
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    output logic       accept,
    output logic [3:0] rndNo,
    output logic       enbSB,
    output logic       enbSR,
    output logic       enbMC,
    output logic       enbAR,
    output logic       enbKS,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] NR_L   = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RND0  = 3'd1,
        S_RNDS  = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The counter is loaded with the round number the next
    // state will display, so rndNo can be taken straight from cnt_q.
    // NOTE: defaults are assigned before the case so no path leaves a
    // combinational output unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (start) state_d = S_RND0;
            end
            S_RND0: begin
                state_d = S_RNDS;
                cnt_d   = 4'd1;
            end
            S_RNDS: begin
                if (cnt_q == NR_M1) begin
                    state_d = S_FINAL;
                    cnt_d   = NR_L;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            S_FINAL: begin
                state_d = S_DONE;
                cnt_d   = 4'd0;
            end
            S_DONE: begin
                cnt_d   = 4'd0;
                state_d = start ? S_RND0 : S_IDLE;
            end
            // Unreachable encodings fall back to IDLE on the next edge.
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Moore output decode.
    always_comb begin
        accept = 1'b0;
        rndNo  = 4'd0;
        enbSB  = 1'b0;
        enbSR  = 1'b0;
        enbMC  = 1'b0;
        enbAR  = 1'b0;
        enbKS  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            S_RND0: begin
                accept = 1'b1;
                enbAR  = 1'b1;
                busy   = 1'b1;
            end
            S_RNDS: begin
                rndNo  = cnt_q;
                enbSB  = 1'b1;
                enbSR  = 1'b1;
                enbMC  = 1'b1;
                enbAR  = 1'b1;
                enbKS  = 1'b1;
                busy   = 1'b1;
            end
            S_FINAL: begin
                rndNo  = cnt_q;
                enbSB  = 1'b1;
                enbSR  = 1'b1;
                enbAR  = 1'b1;
                enbKS  = 1'b1;
                busy   = 1'b1;
            end
            S_DONE: begin
                done   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Drives two controllers (NR=10 and NR=4) with the same start/rstn stream.
// The NR=10 controller also drives a behavioural AES-128 core. Expected control
// outputs come from a cycle-position model: pos = cycles since the accepted
// start, where 0 means idle. Expected ciphertext comes from a straight AES-128
// reference function.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rstn;
    logic start;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic       acc10, sb10, sr10, mc10, ar10, ks10, busy10, done10;
    logic [3:0] rnd10;
    logic       acc4, sb4, sr4, mc4, ar4, ks4, busy4, done4;
    logic [3:0] rnd4;

    aes_round_ctrl #(.NR(10)) u_dut10 (
        .clk(clk), .rstn(rstn), .start(start),
        .accept(acc10), .rndNo(rnd10), .enbSB(sb10), .enbSR(sr10),
        .enbMC(mc10), .enbAR(ar10), .enbKS(ks10), .busy(busy10), .done(done10)
    );

    aes_round_ctrl #(.NR(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .start(start),
        .accept(acc4), .rndNo(rnd4), .enbSB(sb4), .enbSR(sr4),
        .enbMC(mc4), .enbAR(ar4), .enbKS(ks4), .busy(busy4), .done(done4)
    );

    wire [11:0] out10 = {acc10, rnd10, sb10, sr10, mc10, ar10, ks10, busy10, done10};
    wire [11:0] out4  = {acc4,  rnd4,  sb4,  sr4,  mc4,  ar4,  ks4,  busy4,  done4};

    // ---------------- AES-128 helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse (b^254) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r = 8'h01;
        logic [7:0] e = 8'd254;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, b);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(gb(s, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = gb(s, 4*((c+r)%4) + r);
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    // Round key r from round key r-1.
    function automatic logic [127:0] kexp(input logic [127:0] k, input int r);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t, w0, w1, w2, w3;
        for (int i = 1; i < r; i++) rc = xt(rc);
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s = p ^ k;
        for (int r = 1; r <= 10; r++) begin
            k = kexp(k, r);
            s = shift_rows(sub_bytes(s));
            if (r != 10) s = mix_columns(s);
            s ^= k;
        end
        return s;
    endfunction

    // ---------------- behavioural core driven by the NR=10 controller ----------------
    logic [127:0] pt, key;
    logic [127:0] ct_q, rk_q;

    always @(posedge clk) begin
        logic [127:0] st, k;
        st = acc10 ? pt  : ct_q;
        k  = acc10 ? key : rk_q;
        if (ks10) k  = kexp(k, int'(rnd10));
        if (sb10) st = sub_bytes(st);
        if (sr10) st = shift_rows(st);
        if (mc10) st = mix_columns(st);
        if (ar10) st = st ^ k;
        ct_q <= st;
        rk_q <= k;
    end

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    int pos10  = 0;
    int pos4   = 0;
    logic         hold_vec  = 1'b0;
    logic         res_valid = 1'b0;
    logic [127:0] cap_pt, cap_key, exp_ct;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Position after one edge: start is honoured only when idle (0) or done (nr+2).
    function automatic int nxt(input int p, input int nr, input logic s, input logic r);
        if (!r) return 0;
        if (p == 0 || p == nr + 2) return s ? 1 : 0;
        return p + 1;
    endfunction

    // Round r = p-1 for p in 1..nr+1; done at p = nr+2.
    function automatic logic [11:0] exp_out(input int p, input int nr);
        logic in_rnd = (p >= 1) && (p <= nr + 1);
        logic full   = (p >= 2) && (p <= nr + 1);
        logic [3:0] rn = in_rnd ? 4'(p - 1) : 4'd0;
        return {p == 1, rn, full, full, (p >= 2) && (p <= nr), in_rnd, full, in_rnd, p == nr + 2};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic r);
        start = s;
        rstn  = r;
        if (!hold_vec) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
        end
        if (pos10 == 1) begin
            cap_pt  = pt;
            cap_key = key;
        end
        @(posedge clk);
        pos10 = nxt(pos10, 10, s, r);
        pos4  = nxt(pos4,  4,  s, r);
        #1;
        check("ctl_nr10", 128'(out10), 128'(exp_out(pos10, 10)));
        check("ctl_nr4",  128'(out4),  128'(exp_out(pos4, 4)));
        if (!r) res_valid = 1'b0;
        if (pos10 == 12) begin
            exp_ct = aes_ref(cap_pt, cap_key);
            check("ct_done", ct_q, exp_ct);
            res_valid = 1'b1;
        end else if (pos10 != 0) begin
            res_valid = 1'b0;
        end else if (res_valid) begin
            check("ct_hold", ct_q, exp_ct);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        start = 1'b1;
        rstn  = 1'b0;
        pt    = '0;
        key   = '0;

        // Reset held with start asserted, then idle.
        repeat (3) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1);

        // FIPS-197 C.1 single block; done 12 cycles after the start edge.
        hold_vec = 1'b1;
        pt  = FIPS_PT;
        key = FIPS_KEY;
        step(1'b1, 1'b1);
        repeat (11) step(1'b0, 1'b1);
        check("done_at_12", 128'(done10), 128'(1'b1));
        check("fips_ct", ct_q, FIPS_CT);
        repeat (3) step(1'b0, 1'b1);
        check("fips_ct_idle", ct_q, FIPS_CT);
        hold_vec = 1'b0;

        // Start during rndNo=3 and rndNo=10 is ignored; start in DONE chains.
        step(1'b1, 1'b1);
        for (int i = 0; i < 24; i++)
            step((pos10 == 4) || (pos10 == 11) || (pos10 == 12 && i < 14), 1'b1);
        repeat (3) step(1'b0, 1'b1);

        // Abort at rndNo=5, then a clean FIPS block.
        step(1'b1, 1'b1);
        while (pos10 != 6) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("abort_idle", 128'(out10), 128'(0));
        repeat (2) step(1'b0, 1'b1);
        hold_vec = 1'b1;
        pt  = FIPS_PT;
        key = FIPS_KEY;
        step(1'b1, 1'b1);
        repeat (11) step(1'b0, 1'b1);
        check("fips_ct_after_abort", ct_q, FIPS_CT);
        hold_vec = 1'b0;
        repeat (2) step(1'b0, 1'b1);

        // Randomised start/reset traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(3) == 0, $urandom_range(39) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
